// File: rtl/res_stream_out_pkg.sv
// Shared constants and state encoding for the matrix-multiply coprocessor datapath.
package res_stream_out_pkg;

    localparam int unsigned M            = 64;   // rows of result
    localparam int unsigned N            = 8;    // inner dimension, used by the engine
    localparam int unsigned P            = 4;    // columns of result
    localparam int unsigned Width        = 8;    // bits per result RAM word
    localparam int unsigned AxisWidth    = 32;   // stream data width
    localparam int unsigned ResDepthBits = 9;    // result RAM address width
    localparam int unsigned NumWords     = M * P;
    // Counters must reach NumWords itself, not just NumWords-1
    localparam int unsigned CntWidth     = $clog2(NumWords + 1);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } stream_state_e;

endpackage

// File: rtl/res_skid_buffer.sv
// Two-entry FIFO: head register drives the stream directly, skid absorbs one extra word.
module res_skid_buffer
    import res_stream_out_pkg::*;
#(
    parameter int unsigned DataWidth = Width
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] head_data,
    output logic                 full,
    output logic [1:0]           count
);

    logic [DataWidth-1:0] head_q;
    logic [DataWidth-1:0] skid_q;
    logic [1:0]           count_q;

    // Head only changes on pop or when empty, so data is stable while the consumer stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= push_data;
                    end else begin
                        skid_q <= push_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= skid_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; caller never pops an empty buffer
                    if (count_q == 2'd2) begin
                        head_q <= skid_q;
                        skid_q <= push_data;
                    end else begin
                        head_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs
    always_comb begin
        head_data = head_q;
        count     = count_q;
        full      = (count_q == 2'd2);
    end

endmodule

// File: rtl/res_stream_out.sv
// Drains the result RAM onto an AXI4-Stream master after each rising edge of mm_done.
module res_stream_out
    import res_stream_out_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mm_done,
    output logic                    RES_read_en,
    output logic [ResDepthBits-1:0] RES_read_address,
    input  logic [Width-1:0]        RES_read_data_out,
    output logic                    M_AXIS_TVALID,
    output logic [AxisWidth-1:0]    M_AXIS_TDATA,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic                    busy,
    output logic                    out_done
);

    stream_state_e       state_q;
    logic                mm_done_prev_q;
    logic [CntWidth-1:0] rd_cnt_q;
    logic [CntWidth-1:0] tx_cnt_q;
    logic                rd_inflight_q;
    logic                busy_q;
    logic                out_done_q;

    logic                fifo_full;
    logic [1:0]          fifo_count;
    logic [Width-1:0]    fifo_data;
    logic                fifo_valid;
    logic                pop;
    logic                last_pop;
    logic                trigger;
    logic [2:0]          occ_after;
    logic                space_ok;

    res_skid_buffer #(
        .DataWidth (Width)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rd_inflight_q),
        .push_data (RES_read_data_out),
        .pop       (pop),
        .head_data (fifo_data),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Handshake, trigger detection and read issue decision
    always_comb begin
        fifo_valid = (fifo_count != 2'd0);
        pop        = fifo_valid && M_AXIS_TREADY;
        last_pop   = pop && (tx_cnt_q == CntWidth'(NumWords - 1));
        trigger    = (state_q == StIdle) && mm_done && !mm_done_prev_q;
        // Words buffered plus in flight once this cycle's handshake has retired
        occ_after  = 3'(fifo_count) + 3'(rd_inflight_q) - 3'(pop);
        space_ok   = fifo_full ? (pop && !rd_inflight_q) : (occ_after < 3'd2);
        RES_read_en      = (state_q == StStream) && (rd_cnt_q < CntWidth'(NumWords)) && space_ok;
        RES_read_address = ResDepthBits'(rd_cnt_q);
    end

    // Burst FSM with counters and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            mm_done_prev_q <= 1'b1;  // a Done already high at reset release must not trigger
            rd_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            rd_inflight_q  <= 1'b0;
            busy_q         <= 1'b0;
            out_done_q     <= 1'b0;
        end else begin
            mm_done_prev_q <= mm_done;
            rd_inflight_q  <= RES_read_en;
            out_done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q  <= StStream;
                        busy_q   <= 1'b1;
                        rd_cnt_q <= '0;
                        tx_cnt_q <= '0;
                    end
                end
                StStream: begin
                    if (RES_read_en) begin
                        rd_cnt_q <= rd_cnt_q + CntWidth'(1);
                    end
                    if (pop) begin
                        tx_cnt_q <= tx_cnt_q + CntWidth'(1);
                    end
                    if (last_pop) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        out_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stream outputs; TLAST follows the handshake count so it holds during stalls
    always_comb begin
        M_AXIS_TVALID = fifo_valid;
        M_AXIS_TDATA  = AxisWidth'(fifo_data);
        M_AXIS_TLAST  = fifo_valid && (tx_cnt_q == CntWidth'(NumWords - 1));
        busy          = busy_q;
        out_done      = out_done_q;
    end

endmodule
